// File: rtl/alu_pkg.sv
// Shared types for the ALU command controller: ALU op codes, FSM states, queued command record.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  // Register-file size; the command record's index fields are sized from it.
  localparam int unsigned ALU_NREG = 4;
  localparam int unsigned CMD_RW   = $clog2(ALU_NREG);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [CMD_RW-1:0] rd;
    logic [CMD_RW-1:0] rs;
    logic [CMD_RW-1:0] rt;
    logic              imm_en;
    logic [7:0]        imm;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command queue: single holding register when DEPTH==1, circular buffer otherwise.
// ready is registered from the next occupancy, so it is low in reset and never counts a same-edge pop.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t head_c,
  output logic empty_c,
  output logic ready
);

  if (DEPTH == 1) begin : g_single
    logic full_q;
    cmd_t data_q;
    logic full_nxt;

    always_comb full_nxt = push | (full_q & ~pop);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full_q <= 1'b0;
        data_q <= '0;
        ready  <= 1'b0;
      end else begin
        if (push) data_q <= din;
        full_q <= full_nxt;
        ready  <= ~full_nxt;
      end
    end

    assign head_c  = data_q;
    assign empty_c = ~full_q;
  end else begin : g_ring
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_nxt;
    cmd_t          mem [DEPTH];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_comb count_nxt = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
        ready <= 1'b0;
      end else begin
        if (push) wptr <= ptr_inc(wptr);
        if (pop)  rptr <= ptr_inc(rptr);
        count <= count_nxt;
        ready <= (count_nxt != CW'(DEPTH));
      end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
      if (push) mem[wptr] <= din;
    end

    assign head_c  = mem[rptr];
    assign empty_c = (count == '0);
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side controller for the external 8-bit ALU: queue, regfile, IDLE/EXEC/RESP sequencing.
// Define ALU_CTRL_FIFO_EN for a FIFO_DEPTH-entry command FIFO; otherwise a single holding register.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NREG       = ALU_NREG,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [$clog2(NREG)-1:0] cmd_rd,
  input  logic [$clog2(NREG)-1:0] cmd_rs,
  input  logic [$clog2(NREG)-1:0] cmd_rt,
  input  logic                    cmd_imm_en,
  input  logic [7:0]              cmd_imm,
  output logic [7:0]              alu_a,
  output logic [7:0]              alu_b,
  output logic [2:0]              alu_op,
  input  logic [7:0]              alu_y,
  input  logic                    alu_carry,
  input  logic                    alu_zero,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [7:0]              rsp_data,
  output logic                    rsp_carry,
  output logic                    rsp_zero
);

`ifdef ALU_CTRL_FIFO_EN
  localparam int unsigned QDEPTH = FIFO_DEPTH;
`else
  // Single holding register; FIFO_DEPTH has no effect in this build.
  localparam int unsigned QDEPTH = 1 + 0 * FIFO_DEPTH;
`endif

  state_t            state;
  logic [7:0]        regs [NREG];
  logic [CMD_RW-1:0] wr_rd;
  cmd_t              cmd_in;
  cmd_t              head;
  logic              q_empty;
  logic              push;
  logic              pop;

  always_comb begin
    cmd_in        = '0;
    cmd_in.op     = cmd_op;
    cmd_in.rd     = CMD_RW'(cmd_rd);
    cmd_in.rs     = CMD_RW'(cmd_rs);
    cmd_in.rt     = CMD_RW'(cmd_rt);
    cmd_in.imm_en = cmd_imm_en;
    cmd_in.imm    = cmd_imm;
  end

  assign push = cmd_valid & cmd_ready;
  assign pop  = (state == ST_IDLE) & ~q_empty;

  alu_cmd_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .din     (cmd_in),
    .pop     (pop),
    .head_c  (head),
    .empty_c (q_empty),
    .ready   (cmd_ready)
  );

  // One command in flight: operands read in IDLE see every earlier write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      wr_rd     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!q_empty) begin
            alu_a  <= regs[head.rs];
            alu_b  <= head.imm_en ? head.imm : regs[head.rt];
            alu_op <= head.op;
            wr_rd  <= head.rd;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data    <= alu_y;
          rsp_carry   <= alu_carry;
          rsp_zero    <= alu_zero;
          rsp_valid   <= 1'b1;
          regs[wr_rd] <= alu_y;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomised bench for alu_cmd_ctrl against a transaction-level model; also models the external ALU.
// Honours ALU_CTRL_FIFO_EN for the expected queue capacity.
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  localparam int NREG = 4;
  localparam int RW   = $clog2(NREG);
`ifdef ALU_CTRL_FIFO_EN
  localparam int QCAP = 4;
`else
  localparam int QCAP = 1;
`endif

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_op;
  logic [RW-1:0] cmd_rd, cmd_rs, cmd_rt;
  logic          cmd_imm_en;
  logic [7:0]    cmd_imm;
  logic [7:0]    alu_a, alu_b, alu_y;
  logic [2:0]    alu_op;
  logic          alu_carry, alu_zero;
  logic          rsp_valid, rsp_ready;
  logic [7:0]    rsp_data;
  logic          rsp_carry, rsp_zero;

  alu_cmd_ctrl #(.NREG(NREG), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU behaviour: {carry, y}
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      ALU_ADD: return {1'b0, a} + {1'b0, b};
      ALU_SUB: return {1'b0, a} - {1'b0, b};
      ALU_AND: return {1'b0, a & b};
      ALU_OR:  return {1'b0, a | b};
      ALU_XOR: return {1'b0, a ^ b};
      ALU_NOT: return {1'b0, ~a};
      ALU_SHL: return {1'b0, a[6:0], 1'b0};
      default: return {2'b00, a[7:1]};
    endcase
  endfunction

  logic [8:0] alu_res;
  assign alu_res   = alu_f(alu_op, alu_a, alu_b);
  assign alu_y     = alu_res[7:0];
  assign alu_carry = alu_res[8];
  assign alu_zero  = (alu_res[7:0] == 8'h00);

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       z;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mreg [NREG];
  int         n_vec = 0;
  int         n_err = 0;
  int         rr_mode = 0;  // 0: rsp_ready high, 1: low, 2: random

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < NREG; i++) mreg[i] = 8'h00;
  endtask

  // In-order execution means the result is fixed the moment a command is accepted.
  task automatic model_accept(input logic [2:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                              input logic [RW-1:0] rt, input logic ie, input logic [7:0] imm);
    logic [8:0] r;
    exp_t e;
    r = alu_f(op, mreg[rs], ie ? imm : mreg[rt]);
    e.d = r[7:0];
    e.c = r[8];
    e.z = (r[7:0] == 8'h00);
    exp_q.push_back(e);
    mreg[rd] = r[7:0];
  endtask

  task automatic send(input logic [2:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                      input logic [RW-1:0] rt, input logic ie, input logic [7:0] imm,
                      input int bound, output bit ok);
    int w;
    w  = 0;
    ok = 1'b0;
    @(negedge clk);
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm_en = ie; cmd_imm = imm;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < bound) begin
      @(negedge clk);
      w++;
    end
    if (cmd_ready) begin
      model_accept(op, rd, rs, rt, ie, imm);
      ok = 1'b1;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic [2:0] op, input logic [RW-1:0] rd,
                          input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic ie,
                          input logic [7:0] imm);
    bit ok;
    send(op, rd, rs, rt, ie, imm, 50, ok);
    if (!ok) check(tag, 32'(ok), 32'd1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || rsp_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    model_clear();
    #1;
    check("rst_rsp", 32'({rsp_valid, rsp_carry, rsp_zero, rsp_data}), 32'd0);
    check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    check("rst_ready_held", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_rel", 32'(cmd_ready), 32'd1);
  endtask

  // Response ready driven just after each rising edge
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Response monitor: order against the model, stability while stalled
  bit         shown = 1'b0;
  logic [9:0] held  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        shown = 1'b0;
      end else if (rsp_valid) begin
        if (!shown) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 32'(rsp_valid), 32'd0);
          end else begin
            check("rsp", 32'({rsp_carry, rsp_zero, rsp_data}),
                  32'({exp_q[0].c, exp_q[0].z, exp_q[0].d}));
          end
          shown = 1'b1;
          held  = {rsp_carry, rsp_zero, rsp_data};
        end else begin
          check("rsp_stall_hold", 32'({rsp_carry, rsp_zero, rsp_data}), 32'(held));
        end
        if (rsp_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          shown = 1'b0;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [2:0] sweep_op  [6];
  logic [7:0] sweep_exp [6];

  initial begin
    bit ok;
    int acc, n;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0;
    cmd_imm_en = 1'b0; cmd_imm = '0;
    model_clear();
    sweep_op  = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_SHL, ALU_SHR};
    sweep_exp = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'h4A, 8'h52};

    do_reset();
    rr_mode = 0;
    @(negedge clk);

    // Latency: accept at E0, rsp_valid visible after E2
    send_chk("lat_acc", ALU_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 10);
    check("latency", 32'(n), 32'd3);
    drain();
    check("imm_add1", 32'({rsp_carry, rsp_zero, rsp_data}), 32'({1'b0, 1'b0, 8'hFF}));

    send_chk("add2_acc", ALU_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01);
    drain();
    check("imm_add2", 32'({rsp_carry, rsp_zero, rsp_data}), 32'({1'b1, 1'b1, 8'h00}));

    // Subtract wrap with borrow
    send_chk("r1_acc", ALU_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
    send_chk("sub_acc", ALU_SUB, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00);
    drain();
    check("sub_wrap", 32'({rsp_carry, rsp_zero, rsp_data}), 32'({1'b1, 1'b0, 8'hFB}));

    // Logic/shift sweep on 8'hA5
    send_chk("a5_acc", ALU_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      send_chk("sweep_acc", sweep_op[i], 2'd2, 2'd1, 2'd0, 1'b1, 8'h0F);
      drain();
      check("sweep", 32'({rsp_carry, rsp_data}), 32'({1'b0, sweep_exp[i]}));
    end
    check("alu_hold", 32'({alu_op, alu_a}), 32'({ALU_SHR, 8'hA5}));

    // Back-pressure: one executing plus QCAP queued, then ready stays low
    rr_mode = 1;
    @(posedge clk);
    #2;
    acc = 0;
    for (int i = 0; i < QCAP + 2; i++) begin
      send(3'($urandom_range(0, 7)), RW'($urandom_range(0, NREG - 1)), RW'($urandom_range(0, NREG - 1)),
           RW'($urandom_range(0, NREG - 1)), 1'($urandom_range(0, 1)), 8'($urandom), 6, ok);
      acc += int'(ok);
    end
    check("bp_accepted", 32'(acc), 32'(QCAP + 1));
    check("bp_ready_low", 32'(cmd_ready), 32'd0);
    rr_mode = 0;
    drain();
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset during EXEC discards the command and its write-back
    send_chk("mid_acc", ALU_ADD, 2'd2, 2'd0, 2'd0, 1'b1, 8'h33);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    send_chk("mid_rd_acc", ALU_ADD, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00);
    drain();
    check("mid_r2_zero", 32'({rsp_zero, rsp_data}), 32'({1'b1, 8'h00}));

    // Randomised traffic with random response stalls
    rr_mode = 2;
    for (int i = 0; i < 200; i++) begin
      send(3'($urandom_range(0, 7)), RW'($urandom_range(0, NREG - 1)), RW'($urandom_range(0, NREG - 1)),
           RW'($urandom_range(0, NREG - 1)), 1'($urandom_range(0, 1)), 8'($urandom), 200, ok);
      if (!ok) check("rand_accept", 32'(ok), 32'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rr_mode = 0;
    drain();
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
